// File: rtl/dmem_pkg.sv
// Shared types for the multi-channel data memory: channel FSM states and
// the latency counter sizing helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_BUSY  = 2'd1,
        CH_RESP  = 2'd2,
        CH_DRAIN = 2'd3
    } channel_state_t;

    // The counter only has to hold latency-2 (the BUSY dwell before RESP).
    function automatic int cnt_bits(input int max_latency);
        return (max_latency <= 2) ? 1 : $clog2(max_latency - 1);
    endfunction

endpackage

// File: rtl/dmem_channel_fsm.sv
// One request channel: accepts a read or write, waits its latency, pulses a
// registered ready, then drains until both valids drop.
module dmem_channel_fsm
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read_valid,
    input  logic [ADDR_BITS-1:0] read_address,
    input  logic                 write_valid,
    input  logic [ADDR_BITS-1:0] write_address,
    input  logic [DATA_BITS-1:0] write_data,
    input  logic [DATA_BITS-1:0] array_word,
    output logic                 read_ready,
    output logic [DATA_BITS-1:0] read_data,
    output logic                 write_ready,
    output logic                 commit_en,
    output logic [ADDR_BITS-1:0] commit_address,
    output logic [DATA_BITS-1:0] commit_data
);

    localparam int MAX_LAT  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_BITS = cnt_bits(MAX_LAT);
    localparam int RD_PRE   = (READ_LATENCY  > 1) ? READ_LATENCY  - 2 : 0;
    localparam int WR_PRE   = (WRITE_LATENCY > 1) ? WRITE_LATENCY - 2 : 0;

    channel_state_t        state_r, state_s;
    logic [CNT_BITS-1:0]   cnt_r, cnt_s;
    logic                  accept_s;
    logic                  is_read_r;
    logic [ADDR_BITS-1:0]  addr_r;
    logic [DATA_BITS-1:0]  data_r;
    logic                  read_ready_r;
    logic                  write_ready_r;
    logic [DATA_BITS-1:0]  read_data_r;

    // Next-state and latency counter; read wins when both valids are high.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        case (state_r)
            CH_IDLE: begin
                if (read_valid) begin
                    accept_s = 1'b1;
                    state_s  = (READ_LATENCY == 1) ? CH_RESP : CH_BUSY;
                    cnt_s    = CNT_BITS'(RD_PRE);
                end else if (write_valid) begin
                    accept_s = 1'b1;
                    state_s  = (WRITE_LATENCY == 1) ? CH_RESP : CH_BUSY;
                    cnt_s    = CNT_BITS'(WR_PRE);
                end else begin
                    state_s  = CH_IDLE;
                end
            end
            CH_BUSY: begin
                if (cnt_r == CNT_BITS'(0)) begin
                    state_s = CH_RESP;
                end else begin
                    cnt_s = cnt_r - CNT_BITS'(1);
                end
            end
            CH_RESP: begin
                state_s = CH_DRAIN;
            end
            CH_DRAIN: begin
                if (!read_valid && !write_valid) begin
                    state_s = CH_IDLE;
                end else begin
                    state_s = CH_DRAIN;
                end
            end
            default: begin
                state_s = CH_IDLE;
            end
        endcase
    end

    // State, latched request and registered response strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= CH_IDLE;
            cnt_r         <= '0;
            is_read_r     <= 1'b0;
            addr_r        <= '0;
            data_r        <= '0;
            read_ready_r  <= 1'b0;
            write_ready_r <= 1'b0;
            read_data_r   <= '0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            read_ready_r  <= (state_r == CH_RESP) && is_read_r;
            write_ready_r <= (state_r == CH_RESP) && !is_read_r;
            if (accept_s) begin
                is_read_r <= read_valid;
                addr_r    <= read_valid ? read_address : write_address;
                // Reads snapshot the array word before this edge's commits.
                data_r    <= read_valid ? array_word : write_data;
            end
            if ((state_r == CH_RESP) && is_read_r) begin
                read_data_r <= data_r;
            end
        end
    end

    assign read_ready     = read_ready_r;
    assign write_ready    = write_ready_r;
    assign read_data      = read_data_r;
    assign commit_en      = (state_r == CH_RESP) && !is_read_r;
    assign commit_address = addr_r;
    assign commit_data    = data_r;

endmodule

// File: rtl/dmem_channel_ram.sv
// Shared data memory with NUM_CHANNELS independent latency-modelled ports.
// Optional host preload port enabled by defining DMEM_HOST_PORT_EN.
module dmem_channel_ram
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] mem_read_valid,
    input  logic [ADDR_BITS-1:0]    mem_read_address [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_read_ready,
    output logic [DATA_BITS-1:0]    mem_read_data    [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0] mem_write_valid,
    input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
    input  logic [DATA_BITS-1:0]    mem_write_data    [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_write_ready
`ifdef DMEM_HOST_PORT_EN
    ,
    input  logic                    host_write_en,
    input  logic [ADDR_BITS-1:0]    host_write_address,
    input  logic [DATA_BITS-1:0]    host_write_data
`endif
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0]    mem_r [DEPTH];
    logic [NUM_CHANNELS-1:0] commit_en_s;
    logic [ADDR_BITS-1:0]    commit_address_s [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    commit_data_s    [NUM_CHANNELS];

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        dmem_channel_fsm #(
            .ADDR_BITS    (ADDR_BITS),
            .DATA_BITS    (DATA_BITS),
            .READ_LATENCY (READ_LATENCY),
            .WRITE_LATENCY(WRITE_LATENCY)
        ) u_fsm (
            .clk           (clk),
            .reset         (reset),
            .read_valid    (mem_read_valid[g]),
            .read_address  (mem_read_address[g]),
            .write_valid   (mem_write_valid[g]),
            .write_address (mem_write_address[g]),
            .write_data    (mem_write_data[g]),
            .array_word    (mem_r[mem_read_address[g]]),
            .read_ready    (mem_read_ready[g]),
            .read_data     (mem_read_data[g]),
            .write_ready   (mem_write_ready[g]),
            .commit_en     (commit_en_s[g]),
            .commit_address(commit_address_s[g]),
            .commit_data   (commit_data_s[g])
        );
    end

    // Array update: later assignments win, so higher channels then host override.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (commit_en_s[c]) begin
                    mem_r[commit_address_s[c]] <= commit_data_s[c];
                end
            end
`ifdef DMEM_HOST_PORT_EN
            if (host_write_en) begin
                mem_r[host_write_address] <= host_write_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dmem_channel_ram.sv
// Self-checking bench for dmem_channel_ram: transaction-level model of the
// main instance plus a latency-1 instance (host port when DMEM_HOST_PORT_EN).
module tb_dmem_channel_ram;

    localparam int RL = 2;
    localparam int WL = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rv = 4'd0, wv = 4'd0, rrdy, wrdy;
    logic [7:0] ra [4], wa [4], wd [4], rdata [4];
    logic [3:0] rv1 = 4'd0, wv1 = 4'd0, rrdy1, wrdy1;
    logic [7:0] ra1 [4], wa1 [4], wd1 [4], rdata1 [4];
`ifdef DMEM_HOST_PORT_EN
    logic       hwe = 1'b0;
    logic [7:0] ha = 8'd0, hd = 8'd0;
    logic       hwe0 = 1'b0;
    logic [7:0] ha0 = 8'd0, hd0 = 8'd0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_channel_ram dut (
        .clk(clk), .reset(reset),
        .mem_read_valid(rv), .mem_read_address(ra),
        .mem_read_ready(rrdy), .mem_read_data(rdata),
        .mem_write_valid(wv), .mem_write_address(wa),
        .mem_write_data(wd), .mem_write_ready(wrdy)
`ifdef DMEM_HOST_PORT_EN
        , .host_write_en(hwe0), .host_write_address(ha0), .host_write_data(hd0)
`endif
    );

    dmem_channel_ram #(.READ_LATENCY(1), .WRITE_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .mem_read_valid(rv1), .mem_read_address(ra1),
        .mem_read_ready(rrdy1), .mem_read_data(rdata1),
        .mem_write_valid(wv1), .mem_write_address(wa1),
        .mem_write_data(wd1), .mem_write_ready(wrdy1)
`ifdef DMEM_HOST_PORT_EN
        , .host_write_en(hwe), .host_write_address(ha), .host_write_data(hd)
`endif
    );

    // Transaction model of the main instance: each request completes LAT edges
    // after acceptance; reads see memory as it was before that acceptance edge.
    bit         m_live = 1'b0;
    int         mcyc = 0;
    bit         m_busy [4], m_drain [4], m_rd [4];
    int         m_done [4];
    logic [7:0] m_addr [4], m_val [4];
    logic [7:0] mem_m [256];
    bit         exp_rr [4], exp_wr [4];
    logic [7:0] exp_rd [4];

    always @(posedge clk) begin
        mcyc++;
        if (reset) begin
            m_live = 1'b1;
            for (int c = 0; c < 4; c++) begin
                m_busy[c] = 1'b0; m_drain[c] = 1'b0;
                exp_rr[c] = 1'b0; exp_wr[c] = 1'b0; exp_rd[c] = 8'h00;
            end
            for (int a = 0; a < 256; a++) mem_m[a] = 8'h00;
        end else begin
            for (int c = 0; c < 4; c++) begin
                exp_rr[c] = 1'b0;
                exp_wr[c] = 1'b0;
                if (!m_busy[c] && !m_drain[c]) begin
                    if (rv[c] || wv[c]) begin
                        m_busy[c] = 1'b1;
                        m_rd[c]   = rv[c];
                        m_addr[c] = rv[c] ? ra[c] : wa[c];
                        m_val[c]  = rv[c] ? mem_m[ra[c]] : wd[c];
                        m_done[c] = mcyc + (rv[c] ? RL : WL);
                    end
                end else if (m_drain[c] && !rv[c] && !wv[c]) begin
                    m_drain[c] = 1'b0;
                end
            end
            for (int c = 0; c < 4; c++) begin
                if (m_busy[c] && m_done[c] == mcyc) begin
                    m_busy[c]  = 1'b0;
                    m_drain[c] = 1'b1;
                    if (m_rd[c]) begin
                        exp_rr[c] = 1'b1;
                        exp_rd[c] = m_val[c];
                    end else begin
                        exp_wr[c] = 1'b1;
                        mem_m[m_addr[c]] = m_val[c];
                    end
                end
            end
        end
    end

    // Every-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        if (m_live) begin
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (rrdy[c] !== exp_rr[c] || wrdy[c] !== exp_wr[c] || rdata[c] !== exp_rd[c]) begin
                    errors++;
                    $display("FAIL cycle_cmp t=%0t ch%0d: got rr=%b wr=%b rd=%h expected rr=%b wr=%b rd=%h",
                             $time, c, rrdy[c], wrdy[c], rdata[c], exp_rr[c], exp_wr[c], exp_rd[c]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one request at a negedge; return at the negedge after its sampling edge.
    task automatic issue(input bit sel, input int ch, input bit rd, input logic [7:0] a,
                         input logic [7:0] d, input bit hold);
        if (sel) begin
            if (rd) begin rv1[ch] = 1'b1; ra1[ch] = a; end
            else begin wv1[ch] = 1'b1; wa1[ch] = a; wd1[ch] = d; end
        end else begin
            if (rd) begin rv[ch] = 1'b1; ra[ch] = a; end
            else begin wv[ch] = 1'b1; wa[ch] = a; wd[ch] = d; end
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            if (sel) begin rv1[ch] = 1'b0; wv1[ch] = 1'b0; end
            else begin rv[ch] = 1'b0; wv[ch] = 1'b0; end
        end
    endtask

    // Count edges after the sampling edge until the ready strobe (bounded).
    task automatic wait_ready(input bit sel, input int ch, input bit rd, output int n);
        logic r;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            r = rd ? (sel ? rrdy1[ch] : rrdy[ch]) : (sel ? wrdy1[ch] : wrdy[ch]);
        end while (!r && n < 12);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        int pulses;
        for (int c = 0; c < 4; c++) begin
            ra[c] = 8'h00; wa[c] = 8'h00; wd[c] = 8'h00;
            ra1[c] = 8'h00; wa1[c] = 8'h00; wd1[c] = 8'h00;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rdy", {28'd0, rrdy | wrdy}, 32'd0);
        check("reset_rdata", {24'd0, rdata[3]}, 32'd0);
        reset = 1'b0;
        idle(1);

        // Write then read on ch0
        issue(1'b0, 0, 1'b0, 8'h10, 8'hA5, 1'b0);
        wait_ready(1'b0, 0, 1'b0, n);
        check("wr_latency", n, 32'd2);
        idle(2);
        issue(1'b0, 0, 1'b1, 8'h10, 8'h00, 1'b0);
        wait_ready(1'b0, 0, 1'b1, n);
        check("rd_latency", n, 32'd2);
        check("rd_data_a5", {24'd0, rdata[0]}, 32'hA5);
        check("model_a5", {24'd0, exp_rd[0]}, 32'hA5);
        idle(2);

        // Held read valid on ch1: single pulse, then drain until valid drops
        issue(1'b0, 1, 1'b1, 8'h10, 8'h00, 1'b1);
        wait_ready(1'b0, 1, 1'b1, n);
        check("held_first_lat", n, 32'd2);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rrdy[1]) pulses++;
        end
        check("held_extra_pulses", pulses, 32'd0);
        rv[1] = 1'b0;
        idle(1);
        issue(1'b0, 1, 1'b1, 8'h10, 8'h00, 1'b0);
        wait_ready(1'b0, 1, 1'b1, n);
        check("after_drain_lat", n, 32'd2);
        idle(2);

        // Same-edge hazard: ch2 captures 0x20 at the edge ch0's write commits
        issue(1'b0, 2, 1'b1, 8'h10, 8'h00, 1'b0);
        wait_ready(1'b0, 2, 1'b1, n);
        check("ch2_preload", {24'd0, rdata[2]}, 32'hA5);
        idle(2);
        wv[0] = 1'b1; wa[0] = 8'h20; wd[0] = 8'h33;
        @(posedge clk); @(negedge clk);
        wv[0] = 1'b0;
        @(posedge clk); @(negedge clk);
        rv[2] = 1'b1; ra[2] = 8'h20;
        @(posedge clk); @(negedge clk);
        rv[2] = 1'b0;
        check("hazard_wr_ready", {31'd0, wrdy[0]}, 32'd1);
        wait_ready(1'b0, 2, 1'b1, n);
        check("hazard_lat", n, 32'd2);
        check("hazard_old", {24'd0, rdata[2]}, 32'h00);
        idle(2);
        issue(1'b0, 2, 1'b1, 8'h20, 8'h00, 1'b0);
        wait_ready(1'b0, 2, 1'b1, n);
        check("hazard_new", {24'd0, rdata[2]}, 32'h33);
        idle(2);

        // Collision: ch1 and ch3 write 0x05 on the same edge
        wv[1] = 1'b1; wa[1] = 8'h05; wd[1] = 8'h11;
        wv[3] = 1'b1; wa[3] = 8'h05; wd[3] = 8'h22;
        @(posedge clk); @(negedge clk);
        wv[1] = 1'b0; wv[3] = 1'b0;
        wait_ready(1'b0, 1, 1'b0, n);
        check("collide_lat", n, 32'd2);
        check("collide_ch3_rdy", {31'd0, wrdy[3]}, 32'd1);
        idle(2);
        issue(1'b0, 0, 1'b1, 8'h05, 8'h00, 1'b0);
        wait_ready(1'b0, 0, 1'b1, n);
        check("collide_winner", {24'd0, rdata[0]}, 32'h22);
        idle(2);

        // Concurrent mixed traffic on all channels, checked by the model
        for (int k = 0; k < 40; k++) begin
            for (int c = 0; c < 4; c++) begin
                rv[c] = ((k + c) % 3 == 0);
                wv[c] = ((k + 2 * c) % 4 == 1);
                ra[c] = 8'((k * 3 + c) % 8);
                wa[c] = 8'((k + c) % 8);
                wd[c] = 8'(k * 16 + c + 1);
            end
            @(negedge clk);
        end
        rv = 4'd0; wv = 4'd0;
        idle(6);

        // Reset while ch0's write 0x40 = 0x77 is in flight
        issue(1'b0, 0, 1'b0, 8'h40, 8'h77, 1'b0);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (wrdy[0]) pulses++;
        end
        check("reset_no_ready", pulses, 32'd0);
        issue(1'b0, 0, 1'b1, 8'h40, 8'h00, 1'b0);
        wait_ready(1'b0, 0, 1'b1, n);
        check("reset_discard", {24'd0, rdata[0]}, 32'h00);
        idle(2);

        // Latency-1 instance
`ifdef DMEM_HOST_PORT_EN
        hwe = 1'b1; ha = 8'h00; hd = 8'h99;
        @(posedge clk); @(negedge clk);
        hwe = 1'b0;
        check("host_no_ready", {28'd0, rrdy1 | wrdy1}, 32'd0);
`else
        issue(1'b1, 0, 1'b0, 8'h00, 8'h99, 1'b0);
        wait_ready(1'b1, 0, 1'b0, n);
        check("lat1_wr", n, 32'd1);
        idle(2);
`endif
        issue(1'b1, 0, 1'b1, 8'h00, 8'h00, 1'b0);
        wait_ready(1'b1, 0, 1'b1, n);
        check("lat1_rd", n, 32'd1);
        check("lat1_data", {24'd0, rdata1[0]}, 32'h99);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
